// File: rtl/comp_pkg.sv
// Shared constants for the comp_track slice: default widths and tracker state encoding.
package comp_pkg;

  localparam int DATAWIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF = 16;

  localparam logic [0:0] ST_EMPTY    = 1'b0;
  localparam logic [0:0] ST_TRACKING = 1'b1;

endpackage

// File: rtl/comp_core.sv
// Combinational magnitude compare of a against b, signed or unsigned per sample.
module comp_core
  import comp_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 signed_en,
  output logic                 gt,
  output logic                 lt,
  output logic                 eq
);

  logic signed [DATAWIDTH-1:0] a_s;
  logic signed [DATAWIDTH-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  // Equality is mode-independent; gt/lt are mutually exclusive with it by construction.
  always_comb begin
    eq = (a == b);
    if (signed_en) begin
      gt = (a_s > b_s);
      lt = (a_s < b_s);
    end else begin
      gt = (a > b);
      lt = (a < b);
    end
  end

endmodule

// File: rtl/comp_track.sv
// Registered a-vs-b comparator with running max/min of a and saturating event counters.
module comp_track
  import comp_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 signed_en,
  input  logic                 clr,
  output logic                 out_valid,
  output logic                 gt,
  output logic                 lt,
  output logic                 eq,
  output logic [DATAWIDTH-1:0] max_a,
  output logic [DATAWIDTH-1:0] min_a,
  output logic                 stats_valid,
  output logic [CNT_WIDTH-1:0] gt_cnt,
  output logic [CNT_WIDTH-1:0] lt_cnt,
  output logic [CNT_WIDTH-1:0] eq_cnt,
  output logic                 sat
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  logic                 cmp_gt_p0, cmp_lt_p0, cmp_eq_p0;
  logic                 a_gt_max_p0, a_lt_min_p0;
  logic                 unused_max_lt, unused_max_eq, unused_min_gt, unused_min_eq;
  logic [0:0]           state, state_nx;
  logic [DATAWIDTH-1:0] max_nx, min_nx;
  logic [CNT_WIDTH-1:0] gt_cnt_nx, lt_cnt_nx, eq_cnt_nx;
  logic                 sat_nx;

  comp_core #(.DATAWIDTH(DATAWIDTH)) u_cmp (
    .a         (a),
    .b         (b),
    .signed_en (signed_en),
    .gt        (cmp_gt_p0),
    .lt        (cmp_lt_p0),
    .eq        (cmp_eq_p0)
  );

  comp_core #(.DATAWIDTH(DATAWIDTH)) u_max (
    .a         (a),
    .b         (max_a),
    .signed_en (signed_en),
    .gt        (a_gt_max_p0),
    .lt        (unused_max_lt),
    .eq        (unused_max_eq)
  );

  comp_core #(.DATAWIDTH(DATAWIDTH)) u_min (
    .a         (a),
    .b         (min_a),
    .signed_en (signed_en),
    .gt        (unused_min_gt),
    .lt        (a_lt_min_p0),
    .eq        (unused_min_eq)
  );

  // Statistics next state: clr wipes first, so a coincident sample restarts from zero.
  always_comb begin
    state_nx  = state;
    max_nx    = max_a;
    min_nx    = min_a;
    gt_cnt_nx = gt_cnt;
    lt_cnt_nx = lt_cnt;
    eq_cnt_nx = eq_cnt;
    sat_nx    = sat;
    if (clr) begin
      state_nx  = ST_EMPTY;
      max_nx    = '0;
      min_nx    = '0;
      gt_cnt_nx = '0;
      lt_cnt_nx = '0;
      eq_cnt_nx = '0;
      sat_nx    = 1'b0;
    end
    if (in_valid) begin
      if (clr || state == ST_EMPTY) begin
        max_nx = a;
        min_nx = a;
      end else begin
        if (a_gt_max_p0) max_nx = a;
        if (a_lt_min_p0) min_nx = a;
      end
      state_nx = ST_TRACKING;
      if (cmp_gt_p0) gt_cnt_nx = sat_inc(gt_cnt_nx);
      if (cmp_lt_p0) lt_cnt_nx = sat_inc(lt_cnt_nx);
      if (cmp_eq_p0) eq_cnt_nx = sat_inc(eq_cnt_nx);
    end
    sat_nx = sat_nx | (&gt_cnt_nx) | (&lt_cnt_nx) | (&eq_cnt_nx);
  end

  // Stage p0 -> p1: compare result and statistics registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      state     <= ST_EMPTY;
      max_a     <= '0;
      min_a     <= '0;
      gt_cnt    <= '0;
      lt_cnt    <= '0;
      eq_cnt    <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      gt        <= in_valid & cmp_gt_p0;
      lt        <= in_valid & cmp_lt_p0;
      eq        <= in_valid & cmp_eq_p0;
      state     <= state_nx;
      max_a     <= max_nx;
      min_a     <= min_nx;
      gt_cnt    <= gt_cnt_nx;
      lt_cnt    <= lt_cnt_nx;
      eq_cnt    <= eq_cnt_nx;
      sat       <= sat_nx;
    end
  end

  assign stats_valid = (state == ST_TRACKING);

endmodule

// File: tb/tb_comp_track.sv
// Directed table-driven bench for comp_track (DATAWIDTH=8, CNT_WIDTH=4).
module tb_comp_track;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       in_valid, signed_en, clr;
  logic [7:0] a, b;
  logic       out_valid, gt, lt, eq, stats_valid, sat;
  logic [7:0] max_a, min_a;
  logic [3:0] gt_cnt, lt_cnt, eq_cnt;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  comp_track #(.DATAWIDTH(8), .CNT_WIDTH(4)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .signed_en   (signed_en),
    .clr         (clr),
    .out_valid   (out_valid),
    .gt          (gt),
    .lt          (lt),
    .eq          (eq),
    .max_a       (max_a),
    .min_a       (min_a),
    .stats_valid (stats_valid),
    .gt_cnt      (gt_cnt),
    .lt_cnt      (lt_cnt),
    .eq_cnt      (eq_cnt),
    .sat         (sat)
  );

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic       c;
    logic       ov, gt, lt, eq;
    logic [7:0] mx, mn;
    logic       sv;
    logic [3:0] gc, lc, ec;
    logic       st;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t e);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e.ov));
    chk({tag, ".gt"}, 32'(gt), 32'(e.gt));
    chk({tag, ".lt"}, 32'(lt), 32'(e.lt));
    chk({tag, ".eq"}, 32'(eq), 32'(e.eq));
    chk({tag, ".max_a"}, 32'(max_a), 32'(e.mx));
    chk({tag, ".min_a"}, 32'(min_a), 32'(e.mn));
    chk({tag, ".stats_valid"}, 32'(stats_valid), 32'(e.sv));
    chk({tag, ".gt_cnt"}, 32'(gt_cnt), 32'(e.gc));
    chk({tag, ".lt_cnt"}, 32'(lt_cnt), 32'(e.lc));
    chk({tag, ".eq_cnt"}, 32'(eq_cnt), 32'(e.ec));
    chk({tag, ".sat"}, 32'(sat), 32'(e.st));
  endtask

  task automatic drive(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                       input logic s, input logic c);
    in_valid  = v;
    a         = aa;
    b         = bb;
    signed_en = s;
    clr       = c;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  vec_t zero_v;

  initial begin
    //            v  a      b      s  c  ov gt lt eq mx     mn     sv gc lc ec st
    vecs[0]  = '{0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 8'd20, 8'd10, 0, 0, 1, 1, 0, 0, 8'd20, 8'd20, 1, 1, 0, 0, 0};
    vecs[2]  = '{1, 8'd10, 8'd20, 0, 0, 1, 0, 1, 0, 8'd20, 8'd10, 1, 1, 1, 0, 0};
    vecs[3]  = '{1, 8'd15, 8'd15, 0, 0, 1, 0, 0, 1, 8'd20, 8'd10, 1, 1, 1, 1, 0};
    vecs[4]  = '{0, 8'd99, 8'd1,  0, 0, 0, 0, 0, 0, 8'd20, 8'd10, 1, 1, 1, 1, 0};
    vecs[5]  = '{1, 8'hF0, 8'h10, 1, 0, 1, 0, 1, 0, 8'd20, 8'hF0, 1, 1, 2, 1, 0};
    vecs[6]  = '{1, 8'hF0, 8'h10, 0, 0, 1, 1, 0, 0, 8'hF0, 8'hF0, 1, 2, 2, 1, 0};
    vecs[7]  = '{1, 8'd5,  8'd9,  0, 1, 1, 0, 1, 0, 8'd5,  8'd5,  1, 0, 1, 0, 0};
    vecs[8]  = '{0, 8'd0,  8'd0,  0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0};
    vecs[9]  = '{1, 8'h80, 8'h7F, 1, 0, 1, 0, 1, 0, 8'h80, 8'h80, 1, 0, 1, 0, 0};
    vecs[10] = '{1, 8'h7F, 8'h80, 1, 0, 1, 1, 0, 0, 8'h7F, 8'h80, 1, 1, 1, 0, 0};
    vecs[11] = '{1, 8'h00, 8'h00, 0, 0, 1, 0, 0, 1, 8'h7F, 8'h00, 1, 1, 1, 1, 0};
    zero_v   = '{0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0};

    // Held in reset with live stimulus: everything stays zero.
    Rst_n = 1'b0;
    drive(1, 8'd20, 8'd10, 0, 0);
    repeat (3) step();
    chk_all("reset", zero_v);

    drive(0, 8'd0, 8'd0, 0, 0);
    step();
    Rst_n = 1'b1;
    step();
    chk_all("post_reset_idle", zero_v);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Saturation of eq_cnt at 15 with CNT_WIDTH=4.
    drive(0, 8'd0, 8'd0, 0, 1);
    step();
    drive(1, 8'd7, 8'd7, 0, 0);
    repeat (14) step();
    chk("sat14.eq_cnt", 32'(eq_cnt), 32'd14);
    chk("sat14.sat", 32'(sat), 32'd0);
    step();
    chk("sat15.eq_cnt", 32'(eq_cnt), 32'd15);
    chk("sat15.sat", 32'(sat), 32'd1);
    repeat (5) step();
    chk("sat20.eq_cnt", 32'(eq_cnt), 32'd15);
    chk("sat20.sat", 32'(sat), 32'd1);
    chk("sat20.eq", 32'(eq), 32'd1);
    drive(0, 8'd0, 8'd0, 0, 1);
    step();
    chk("satclr.eq_cnt", 32'(eq_cnt), 32'd0);
    chk("satclr.sat", 32'(sat), 32'd0);
    chk("satclr.stats_valid", 32'(stats_valid), 32'd0);
    chk("satclr.max_a", 32'(max_a), 32'd0);

    // Idle after clr keeps sat low and stats empty.
    drive(0, 8'd0, 8'd0, 0, 0);
    step();
    chk("idle.sat", 32'(sat), 32'd0);
    chk("idle.out_valid", 32'(out_valid), 32'd0);

    // Mid-stream asynchronous reset between edges.
    drive(1, 8'd3, 8'd1, 0, 0);
    step();
    chk("pre_rst.out_valid", 32'(out_valid), 32'd1);
    chk("pre_rst.stats_valid", 32'(stats_valid), 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk_all("mid_rst", zero_v);
    drive(0, 8'd0, 8'd0, 0, 0);
    #1;
    Rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("after_rst%0d.out_valid", k), 32'(out_valid), 32'd0);
    end
    chk("after_rst.stats_valid", 32'(stats_valid), 32'd0);
    drive(1, 8'd4, 8'd4, 0, 0);
    step();
    chk("restart.out_valid", 32'(out_valid), 32'd1);
    chk("restart.eq", 32'(eq), 32'd1);
    chk("restart.eq_cnt", 32'(eq_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
